// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 LSB-first serialiser with per-frame baud select.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
`timescale 1ns/1ps
module uart_tx_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mode,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count,
    output logic        overflow,
    output logic        miso,
    output logic        busy,
    output logic        wok
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q, overflow_q;
    logic          push, pop;

    state_e        state_q, state_d;
    logic [2:0]    bit_idx_q;
    logic [12:0]   cnt_q, div_q, div_sel;
    logic [7:0]    shift_q;
    logic          par_q;
    logic          bit_done;

    // Acceptance is judged on the registered full flag, so a pop in the same cycle cannot rescue it.
    assign push     = wr_en && !full_q;
    assign bit_done = (cnt_q == div_q - 13'd1);

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;

    always_comb begin
        case (mode)
            4'd1:    div_sel = 13'd2604;
            4'd2:    div_sel = 13'd1302;
            4'd3:    div_sel = 13'd868;
            4'd4:    div_sel = 13'd434;
            default: div_sel = 13'd5208;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
            if (wr_en && full_q) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // State register and per-frame datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_idx_q <= '0;
            cnt_q     <= '0;
            div_q     <= 13'd5208;
            shift_q   <= '0;
            par_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                shift_q   <= mem_q[rptr_q];
                par_q     <= ^mem_q[rptr_q];
                div_q     <= div_sel;
                cnt_q     <= '0;
                bit_idx_q <= '0;
            end else if (state_q != StIdle) begin
                if (bit_done) begin
                    cnt_q <= '0;
                    if (state_q == StData) begin
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_q <= cnt_q + 13'd1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_done) state_d = StData;
            end
            StData: begin
                if (bit_done && bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_done) state_d = StStop;
            end
`endif
            StStop: begin
                // Chain straight into the next start bit so queued bytes stream with no idle gap.
                if (bit_done) begin
                    if (!empty_q) begin
                        pop     = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        miso = 1'b1;
        busy = (state_q != StIdle);
        wok  = 1'b0;
        unique case (state_q)
            StIdle:   miso = 1'b1;
            StStart:  miso = 1'b0;
            StData:   miso = shift_q[0];
`ifdef UART_TX_PARITY_EN
            StParity: miso = par_q;
`endif
            StStop: begin
                miso = 1'b1;
                wok  = bit_done;
            end
            default:  miso = 1'b1;
        endcase
    end

`ifndef UART_TX_PARITY_EN
    logic unused_par;
    assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: a scoreboard of written bytes is checked against frames decoded off miso.
`timescale 1ns/1ps
module tb_uart_tx_buf;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    mode;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full, empty, overflow, miso, busy, wok;
    logic [AW:0]   count;

    int            n_chk = 0;
    int            n_err = 0;
    int            cyc = 0;
    logic [7:0]    sb[$];
    int            starts[$];
    bit            mon_en = 1'b0;

    uart_tx_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .miso     (miso),
        .busy     (busy),
        .wok      (wok)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int div_of(input logic [3:0] m);
        case (m)
            4'd1:    return 2604;
            4'd2:    return 1302;
            4'd3:    return 868;
            4'd4:    return 434;
            default: return 5208;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write(input logic [7:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (c < budget && !(sb.size() == 0 && busy === 1'b0)) begin
            tick(1);
            c++;
        end
        chk("drain_timeout", (sb.size() == 0 && busy === 1'b0), 1);
        tick(2);
    endtask

    // Frame decoder: samples each bit at its midpoint and checks wok timing at the frame end.
    initial begin : monitor
        int d, cur, tgt;
        logic [NB-1:0] bits;
        logic [7:0] exp_b;
        forever begin
            if (!(mon_en && miso === 1'b0 && rst === 1'b0)) begin
                @(posedge clk);
                #1;
            end else begin
                d   = div_of(mode);
                cur = 0;
                starts.push_back(cyc);
                for (int k = 0; k < NB; k++) begin
                    tgt = k * d + d / 2;
                    repeat (tgt - cur) @(posedge clk);
                    #1;
                    cur = tgt;
                    bits[k] = miso;
                end
                repeat (NB * d - 2 - cur) @(posedge clk);
                #1;
                chk("wok_early", wok, 0);
                tick(1);
                chk("wok_pulse", wok, 1);
                chk("busy_in_stop", busy, 1);
                tick(1);
                chk("wok_width", wok, 0);
                chk("start_bit", bits[0], 0);
                chk("stop_bit", bits[NB-1], 1);
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    exp_b = sb.pop_front();
                    chk("frame_data", bits[8:1], exp_b);
`ifdef UART_TX_PARITY_EN
                    chk("parity_bit", bits[9], ^exp_b);
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] stim [6];
        int bad;
        stim = '{8'hA5, 8'h00, 8'hFF, 8'h3C, 8'h5A, 8'hC3};
        rst = 1'b1; mode = 4'd4; wr_en = 1'b0; wr_data = 8'h00;
        tick(3);
        chk("rst_miso", miso, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wok", wok, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);

        // Stream six bytes back-to-back: the first pops at once, four fill the FIFO, the sixth overflows.
        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            write(stim[i]);
            if (i <= int'(DEPTH)) sb.push_back(stim[i]);
            chk("stream_count", count, (i == 0) ? 1 : ((i < int'(DEPTH)) ? i : DEPTH));
            chk("stream_full", full, (i >= int'(DEPTH)));
            chk("stream_overflow", overflow, (i > int'(DEPTH)));
            if (i == 0) chk("miso_before_pop", miso, 1);
            if (i == 1) begin
                chk("miso_fall_latency", miso, 0);
                chk("busy_after_pop", busy, 1);
            end
        end
        drain(30000);
        chk("post_stream_empty", empty, 1);
        chk("post_stream_count", count, 0);
        chk("post_stream_busy", busy, 0);
        chk("overflow_sticky", overflow, 1);
        chk("stream_frames", starts.size(), DEPTH + 1);
        for (int i = 1; i < starts.size(); i++) begin
            chk("stream_gap", starts[i] - starts[i-1], NB * 434);
        end

        // Divisor is held for the whole frame; the switch applies to the next frame only.
        starts.delete();
        mode = 4'd2;
        write(8'h96);
        sb.push_back(8'h96);
        tick(3000);
        mode = 4'd4;
        write(8'h69);
        sb.push_back(8'h69);
        drain(25000);
        chk("mode_frames", starts.size(), 2);
        if (starts.size() == 2) chk("mode_hold_len", starts[1] - starts[0], NB * 1302);

`ifdef UART_TX_PARITY_EN
        write(8'h07);
        sb.push_back(8'h07);
        write(8'h03);
        sb.push_back(8'h03);
        drain(15000);
`endif

        // Reset mid-frame with bytes queued: line idles at once and nothing is resent.
        mon_en = 1'b0;
        mode = 4'd0;
        write(8'h55);
        write(8'h11);
        write(8'h22);
        write(8'h33);
        tick(5207 - 2);
        chk("m0_start_len", miso, 0);
        tick(1);
        chk("m0_bit0", miso, 1);
        chk("m0_queued", count, 3);
        tick(1000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_miso", miso, 1);
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_busy", busy, 0);
        chk("arst_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 2000; c++) begin
            tick(1);
            if (miso !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("quiet_after_rst", bad, 0);

        mon_en = 1'b1;
        mode = 4'd4;
        write(8'h3C);
        sb.push_back(8'h3C);
        drain(8000);
        chk("final_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
